// File: rtl/core_pkg.sv
// Shared register-file types and sizes for the write-back path.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_entry_t;

  // True when a live entry targets the given register.
  function automatic logic entry_hits(input wb_entry_t e, input logic [REG_ADDR_W-1:0] a);
    return e.valid && (e.waddr == a);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_chk.sv
// Protocol and safety properties for the register-file write arbiter.
module reg_wb_arbiter_chk
  import core_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  input logic                  pipe_we,
  input logic                  stall_out,
  input logic                  rf_we,
  input logic [REG_ADDR_W-1:0] rf_waddr
);

  no_pipe_during_stall: assert property (@(posedge clk) disable iff (reset)
    !(pipe_we && stall_out))
    else $error("pipe_we asserted while stall_out high");

  no_r0_write: assert property (@(posedge clk) disable iff (reset)
    rf_we |-> ((rf_waddr != 5'd0) && (int'(rf_waddr) < REG_NUM)))
    else $error("register file write to r0 or out of range");

endmodule

// File: rtl/wb_fifo.sv
// MDU result buffer: circular FIFO with per-entry squash by address and
// two address-match query ports for operand interlocks.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  input  logic                    squash,
  input  logic [REG_ADDR_W-1:0]   squash_addr,
  input  logic [REG_ADDR_W-1:0]   query1,
  input  logic [REG_ADDR_W-1:0]   query2,
  output wb_entry_t               head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    hit1,
  output logic                    hit2
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  assign head = mem[rd_ptr];

  // Address match against stored live entries only.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | entry_hits(mem[i], query1);
      hit2 = hit2 | entry_hits(mem[i], query2);
    end
  end

  // Storage, pointers and occupancy; popped slots are invalidated so that
  // valid always implies occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && entry_hits(mem[i], squash_addr)) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs. buffered MDU
// results, with WAW squash, r0 filtering, starvation stall and pending flags.
module reg_wb_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wdata,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_waddr,
  input  logic [XLEN-1:0]       mdu_wdata,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic                  pending1,
  output logic                  pending2,
  output logic                  stall_out,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);

  wb_entry_t       head;
  wb_entry_t       push_entry;
  logic [OW-1:0]   count;
  logic [OW-1:0]   count_next;
  logic            hit1;
  logic            hit2;
  logic            fifo_empty;
  logic            head_live;
  logic            head_dead;
  logic            pipe_acc;
  logic            push;
  logic            pop;
  logic            grant_head;
  logic [CW-1:0]   starve_cnt;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .squash      (pipe_acc),
    .squash_addr (pipe_waddr),
    .query1      (raddr1),
    .query2      (raddr2),
    .head        (head),
    .count       (count),
    .hit1        (hit1),
    .hit2        (hit2)
  );

  assign pending1 = hit1 && (raddr1 != 5'd0);
  assign pending2 = hit2 && (raddr2 != 5'd0);

  // Arbitration: dead heads drain for free, a starved head beats the pipe,
  // otherwise the pipe wins. A pipe write issued during stall is dropped.
  always_comb begin
    fifo_empty = (count == {OW{1'b0}});
    head_live  = !fifo_empty && head.valid;
    head_dead  = !fifo_empty && !head.valid;
    pipe_acc   = pipe_we && (pipe_waddr != 5'd0) && !stall_out;
    push       = mdu_valid && mdu_ready && (mdu_waddr != 5'd0);
    // A same-cycle push to the pipe's target is older, so it lands already dead.
    push_entry.valid = !(pipe_acc && (pipe_waddr == mdu_waddr));
    push_entry.waddr = mdu_waddr;
    push_entry.wdata = mdu_wdata;
    grant_head = head_live && (stall_out || !pipe_acc);
    pop        = grant_head || head_dead;
    count_next = count + {{(OW-1){1'b0}}, push} - {{(OW-1){1'b0}}, pop};
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (grant_head) begin
      rf_we    <= 1'b1;
      rf_waddr <= head.waddr;
      rf_wdata <= head.wdata;
    end else if (pipe_acc) begin
      rf_we    <= 1'b1;
      rf_waddr <= pipe_waddr;
      rf_wdata <= pipe_wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Starvation tracking, stall request and MDU backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_out  <= 1'b0;
      mdu_ready  <= 1'b0;
    end else begin
      mdu_ready <= (count_next != FULL_CNT);
      if (fifo_empty || grant_head) begin
        starve_cnt <= '0;
        stall_out  <= 1'b0;
      end else begin
        if (head_live && (starve_cnt != LIMIT)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end else begin
          starve_cnt <= starve_cnt;
        end
        stall_out <= stall_out || (starve_cnt == LIMIT);
      end
    end
  end

  reg_wb_arbiter_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .pipe_we   (pipe_we),
    .stall_out (stall_out),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the write-back arbiter.
module tb_reg_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pending1;
  logic        pending2;
  logic        stall_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .mdu_ready(mdu_ready), .raddr1(raddr1), .raddr2(raddr2),
    .pending1(pending1), .pending2(pending2), .stall_out(stall_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
  } ment_t;

  ment_t       q[$];
  int          m_cnt;
  bit          m_stall;
  bit          m_ready;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          tests = 0;
  int          fails = 0;
  logic [4:0]  wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].v && q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge of the reference behaviour, from the inputs held this cycle.
  task automatic model_step();
    int occ;
    bit hv, hd, pok, gh, hs, nstall;
    if (reset) begin
      q.delete();
      m_cnt = 0; m_stall = 0; m_ready = 0;
      m_we = 0; m_waddr = 5'd0; m_wdata = 32'd0;
      return;
    end
    occ = q.size();
    hv = 0; hd = 0;
    if (occ > 0) begin hv = q[0].v; hd = !q[0].v; end
    pok = pipe_we && pipe_waddr != 5'd0 && !m_stall;
    hs  = mdu_valid && m_ready;
    gh  = hv && (m_stall || !pok);
    if (gh) begin
      m_we = 1; m_waddr = q[0].a; m_wdata = q[0].d;
    end else if (pok) begin
      m_we = 1; m_waddr = pipe_waddr; m_wdata = pipe_wdata;
    end else begin
      m_we = 0;
    end
    if (occ == 0 || gh) begin
      m_cnt = 0; m_stall = 0;
    end else begin
      nstall = m_stall || (m_cnt == LIMIT);
      if (hv && m_cnt < LIMIT) m_cnt++;
      m_stall = nstall;
    end
    if (gh || hd) void'(q.pop_front());
    if (pok) foreach (q[i]) if (q[i].a == pipe_waddr) q[i].v = 0;
    if (hs && mdu_waddr != 5'd0)
      q.push_back('{v: !(pok && pipe_waddr == mdu_waddr), a: mdu_waddr, d: mdu_wdata});
    m_ready = (q.size() < DEPTH);
  endtask

  task automatic compare();
    chk("rf_we",     32'(rf_we),     32'(m_we));
    chk("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
    chk("rf_wdata",  rf_wdata,       m_wdata);
    chk("stall_out", 32'(stall_out), 32'(m_stall));
    chk("mdu_ready", 32'(mdu_ready), 32'(m_ready));
    chk("pending1",  32'(pending1),  32'(pend(raddr1)));
    chk("pending2",  32'(pending2),  32'(pend(raddr2)));
    if (rf_we) wlog.push_back(rf_waddr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    pipe_we = 0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    mdu_valid = 0; mdu_waddr = 5'd0; mdu_wdata = 32'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_order[10];
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    reset = 1; idle(); raddr1 = 5'd0; raddr2 = 5'd0;
    m_cnt = 0; m_stall = 0; m_ready = 0; m_we = 0; m_waddr = 5'd0; m_wdata = 32'd0;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    reset = 0; tick();
    chk("ready_after_rst", 32'(mdu_ready), 32'd1);

    // Single pipeline write.
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'hDEADBEEF; tick();
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_addr", 32'(rf_waddr), 32'd3);
    chk("t1_data", rf_wdata, 32'hDEADBEEF);
    idle(); tick();
    chk("t1_we_drop", 32'(rf_we), 32'd0);

    // MDU result with the pipe idle.
    raddr1 = 5'd5; mdu_valid = 1; mdu_waddr = 5'd5; mdu_wdata = 32'h11; tick();
    chk("t2_pend", 32'(pending1), 32'd1);
    chk("t2_we0", 32'(rf_we), 32'd0);
    idle(); tick();
    chk("t2_we", 32'(rf_we), 32'd1);
    chk("t2_addr", 32'(rf_waddr), 32'd5);
    chk("t2_data", rf_wdata, 32'h11);
    chk("t2_pend_drop", 32'(pending1), 32'd0);

    // Write-after-write squash.
    raddr1 = 5'd7; mdu_valid = 1; mdu_waddr = 5'd7; mdu_wdata = 32'hAA; tick();
    chk("t3_pend", 32'(pending1), 32'd1);
    idle(); pipe_we = 1; pipe_waddr = 5'd7; pipe_wdata = 32'hBB; tick();
    chk("t3_we", 32'(rf_we), 32'd1);
    chk("t3_data", rf_wdata, 32'hBB);
    chk("t3_pend_drop", 32'(pending1), 32'd0);
    idle(); tick();
    chk("t3_silent_pop", 32'(rf_we), 32'd0);
    tick();
    chk("t3_no_stale", 32'(rf_we), 32'd0);

    // Starvation: head loses nine cycles in a row.
    pipe_we = 1; pipe_waddr = 5'd9; pipe_wdata = 32'h9;
    mdu_valid = 1; mdu_waddr = 5'd20; mdu_wdata = 32'h55; tick();
    mdu_valid = 0;
    for (int r = 1; r <= 9; r++) begin
      pipe_waddr = 5'(r); pipe_wdata = 32'(r); tick();
      if (r == 8) chk("t4_no_stall_yet", 32'(stall_out), 32'd0);
    end
    chk("t4_stall", 32'(stall_out), 32'd1);
    idle(); tick();
    chk("t4_head_we", 32'(rf_we), 32'd1);
    chk("t4_head_addr", 32'(rf_waddr), 32'd20);
    chk("t4_stall_drop", 32'(stall_out), 32'd0);

    // Fill the FIFO while the pipe is busy; ordering preserved.
    wlog.delete();
    for (int r = 1; r <= 5; r++) begin
      pipe_we = 1; pipe_waddr = 5'(r); pipe_wdata = 32'(r);
      mdu_valid = 1; mdu_waddr = 5'(10 + r); mdu_wdata = 32'(100 + r);
      tick();
      if (r == 4) chk("t5_full", 32'(mdu_ready), 32'd0);
    end
    chk("t5_held", 32'(mdu_ready), 32'd0);
    pipe_we = 0; tick();
    chk("t5_ready_back", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 0;
    repeat (4) tick();
    chk("t5_nwrites", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < wlog.size()) chk("t5_order", 32'(wlog[i]), 32'(exp_order[i]));

    // r0 writes are filtered.
    idle(); pipe_we = 1; pipe_waddr = 5'd0; pipe_wdata = 32'h123;
    mdu_valid = 1; mdu_waddr = 5'd0; mdu_wdata = 32'h456; tick();
    chk("t6_r0_we", 32'(rf_we), 32'd0);
    idle(); tick();
    chk("t6_r0_we2", 32'(rf_we), 32'd0);
    chk("t6_r0_occ", 32'(q.size()), 32'd0);

    // Reset with three entries queued.
    for (int r = 1; r <= 3; r++) begin
      pipe_we = 1; pipe_waddr = 5'(r); pipe_wdata = 32'(r);
      mdu_valid = 1; mdu_waddr = 5'(20 + r); mdu_wdata = 32'(200 + r);
      tick();
    end
    idle(); reset = 1; tick();
    chk("t7_rst_we", 32'(rf_we), 32'd0);
    chk("t7_rst_ready", 32'(mdu_ready), 32'd0);
    tick();
    chk("t7_rst_ready2", 32'(mdu_ready), 32'd0);
    reset = 0; raddr1 = 5'd21; tick();
    chk("t7_empty_pend", 32'(pending1), 32'd0);
    chk("t7_ready", 32'(mdu_ready), 32'd1);
    repeat (3) tick();

    // Randomized traffic; pipe obeys the stall handshake.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      pipe_we    = !m_stall && ($urandom_range(0, 9) < 6);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      mdu_valid  = ($urandom_range(0, 9) < 5);
      mdu_waddr  = 5'($urandom_range(0, 7));
      mdu_wdata  = $urandom;
      raddr1     = 5'($urandom_range(0, 7));
      raddr2     = 5'($urandom_range(0, 7));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
